// File: rtl/vga_pkg.sv
// Shared VGA timing constants and colour types for the scan driver and every renderer.
// The defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_pkg;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FP      = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BP      = 48;
   localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FP      = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BP      = 33;
   localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam int COLOR_W = 12;
   localparam int CNT_W   = 10;
   localparam int CX_W    = 10;
   localparam int CY_W    = 9;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   // True when val lies in the half-open window [lo, lo+len).
   function automatic logic in_window(input logic [CNT_W-1:0] val, input int lo, input int len);
      return (int'(val) >= lo) && (int'(val) < lo + len);
   endfunction

endpackage

// File: rtl/vga_scan_driver_if.sv
// Scan bus between the VGA driver (master) and renderers / display pins (slave).
// The driver publishes scan coordinates and strobes and returns the captured colour to the DAC.
interface vga_scan_driver_if;
   import vga_pkg::*;

   logic [COLOR_W-1:0] pixel_color;
   logic [CX_W-1:0]    cx;
   logic [CY_W-1:0]    cy;
   logic               video_on;
   logic               pixel_tick;
   logic               frame_start;
   logic               vblank_start;
   logic [3:0]         vga_r;
   logic [3:0]         vga_g;
   logic [3:0]         vga_b;
   logic               vga_hs;
   logic               vga_vs;

   modport master (
      input  pixel_color,
      output cx, cy, video_on, pixel_tick, frame_start, vblank_start,
      output vga_r, vga_g, vga_b, vga_hs, vga_vs
   );

   modport slave (
      output pixel_color,
      input  cx, cy, video_on, pixel_tick, frame_start, vblank_start,
      input  vga_r, vga_g, vga_b, vga_hs, vga_vs
   );

endinterface

// File: rtl/vga_pixel_divider.sv
// Divides the system clock down to the pixel rate: a free-running 0..CLK_DIV-1 counter
// whose terminal count is the one-clk pixel_tick strobe.
module vga_pixel_divider #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic pixel_tick
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   assign pixel_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_scan_driver.sv
// VGA scan driver: h/v raster counters, scan coordinates for renderers, colour capture
// into the DAC registers, and syncs delayed one pixel so they line up with the colour.
module vga_scan_driver
   import vga_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int H_VISIBLE = VGA_H_VISIBLE,
   parameter int H_FP      = VGA_H_FP,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BP      = VGA_H_BP,
   parameter int V_VISIBLE = VGA_V_VISIBLE,
   parameter int V_FP      = VGA_V_FP,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BP      = VGA_V_BP
) (
   input  logic               clk,
   input  logic               rst_n,
   vga_scan_driver_if.master  bus
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VISIBLE - 1);

   logic             pixel_tick;

   logic [CNT_W-1:0] h;
   logic [CNT_W-1:0] v;
   logic [CNT_W-1:0] h_next;
   logic [CNT_W-1:0] v_next;
   logic             h_wrap;
   logic             v_wrap;
   logic             next_visible;
   logic             raw_hs;
   logic             raw_vs;

   logic [CX_W-1:0]  cx_q;
   logic [CY_W-1:0]  cy_q;
   logic             video_on_q;
   rgb_t             rgb_q;
   logic             hs_q;
   logic             vs_q;

   vga_pixel_divider #(
      .CLK_DIV    (CLK_DIV)
   ) u_pixel_divider (
      .clk        (clk),
      .rst_n      (rst_n),
      .pixel_tick (pixel_tick)
   );

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      h_wrap = (h == H_LAST);
      v_wrap = h_wrap && (v == V_LAST);
      h_next = h_wrap ? '0 : h + 1'b1;
      v_next = v;
      if (h_wrap) begin
         v_next = v_wrap ? '0 : v + 1'b1;
      end
      next_visible = (int'(h_next) < H_VISIBLE) && (int'(v_next) < V_VISIBLE);
      raw_hs = !in_window(h, H_VISIBLE + H_FP, H_SYNC);
      raw_vs = !in_window(v, V_VISIBLE + V_FP, V_SYNC);
   end

   // Coordinates track the position being entered; colour and syncs capture the one being left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h          <= '0;
         v          <= '0;
         cx_q       <= '0;
         cy_q       <= '0;
         video_on_q <= 1'b0;
         rgb_q      <= '0;
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
      end else if (pixel_tick) begin
         h          <= h_next;
         v          <= v_next;
         video_on_q <= next_visible;
         cx_q       <= next_visible ? h_next : '0;
         cy_q       <= next_visible ? v_next[CY_W-1:0] : '0;
         rgb_q      <= video_on_q ? rgb_t'(bus.pixel_color) : '0;
         hs_q       <= raw_hs;
         vs_q       <= raw_vs;
      end
   end

   assign bus.pixel_tick   = pixel_tick;
   assign bus.cx           = cx_q;
   assign bus.cy           = cy_q;
   assign bus.video_on     = video_on_q;
   assign bus.vga_r        = rgb_q.r;
   assign bus.vga_g        = rgb_q.g;
   assign bus.vga_b        = rgb_q.b;
   assign bus.vga_hs       = hs_q;
   assign bus.vga_vs       = vs_q;
   assign bus.frame_start  = pixel_tick && v_wrap;
   assign bus.vblank_start = pixel_tick && h_wrap && (v == V_VIS_LAST);

endmodule
